// File: rtl/scope_trace_renderer.sv
`default_nettype none
// ============================================================================
// Module   : scope_trace_renderer
// Captures triggered ADC samples into a double-buffered trace memory and paints
// trace, trigger-level line and graticule for each pixel of the timing stage.
// Revision : 1.0
// ============================================================================
module scope_trace_renderer #(
   parameter int H_SIZE       = 640,
   parameter int V_SIZE       = 480,
   parameter int TRACE_BASE   = 367,
   parameter int GRID_SPACING = 64,
   parameter int AUTO_TIMEOUT = 65535
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       sample_valid,
   input  logic [7:0] sample,
   input  logic [7:0] trig_level,
   input  logic       trig_falling,
   input  logic       frame_start,
   input  logic       pixel_active,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   output logic [7:0] colour_R,
   output logic [7:0] colour_G,
   output logic [7:0] colour_B,
   output logic       armed,
   output logic       triggered
);

   localparam int              TW     = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT + 1) : 1;
   localparam logic [TW-1:0]   T_MAX  = '1;
   localparam logic [TW-1:0]   T_LAST = (AUTO_TIMEOUT == 0) ? '0 : TW'(AUTO_TIMEOUT - 1);
   localparam logic [9:0]      H_LAST = 10'(H_SIZE - 1);
   localparam logic [9:0]      H_LIM  = 10'(H_SIZE);
   localparam logic [9:0]      V_LIM  = 10'(V_SIZE);
   localparam logic [9:0]      T_BASE = 10'(TRACE_BASE);
   localparam logic [9:0]      G_MASK = 10'(GRID_SPACING - 1);

   typedef enum logic [1:0] {
      ST_ARMED   = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

   state_t          state_q;
   logic            wr_buf_q;
   logic            disp_valid_q;
   logic            prev_valid_q;
   logic [7:0]      prev_q;
   logic [9:0]      idx_q;
   logic [TW-1:0]   tcnt_q;
   logic            armed_q;
   logic            triggered_q;

   logic [7:0]      mem_q [0:2047];
   logic [7:0]      rd_data_q;
   logic [9:0]      x1_q;
   logic [9:0]      y1_q;
   logic            act1_q;
   logic [7:0]      r_q, g_q, b_q;

   logic            w_trig_hit;
   logic            w_timeout;
   logic            w_start;
   logic            w_wr_en;
   logic [10:0]     w_wr_addr;

   // Trigger test only once a previous sample exists to compare against.
   always_comb begin
      w_trig_hit = 1'b0;
      if (prev_valid_q) begin
         if (trig_falling)
            w_trig_hit = (prev_q > trig_level) && (sample <= trig_level);
         else
            w_trig_hit = (prev_q < trig_level) && (sample >= trig_level);
      end
      w_timeout = (AUTO_TIMEOUT != 0) && (tcnt_q == T_LAST);
      w_start   = (state_q == ST_ARMED) && sample_valid && (w_trig_hit || w_timeout);
      w_wr_en   = sample_valid && (w_start || (state_q == ST_CAPTURE));
      w_wr_addr = {wr_buf_q, (w_start ? 10'd0 : idx_q)};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_ARMED;
         wr_buf_q     <= 1'b0;
         disp_valid_q <= 1'b0;
         prev_valid_q <= 1'b0;
         prev_q       <= 8'd0;
         idx_q        <= 10'd0;
         tcnt_q       <= '0;
         armed_q      <= 1'b1;
         triggered_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_ARMED: begin
               if (sample_valid) begin
                  if (w_trig_hit || w_timeout) begin
                     idx_q       <= 10'd1;
                     state_q     <= ST_CAPTURE;
                     armed_q     <= 1'b0;
                     triggered_q <= 1'b1;
                  end else begin
                     if (tcnt_q != T_MAX)
                        tcnt_q <= tcnt_q + 1'b1;
                     prev_q       <= sample;
                     prev_valid_q <= 1'b1;
                  end
               end
            end
            ST_CAPTURE: begin
               if (sample_valid) begin
                  idx_q <= idx_q + 10'd1;
                  if (idx_q == H_LAST)
                     state_q <= ST_FULL;
               end
            end
            ST_FULL: begin
               // Swap only at frame start so the visible frame never tears.
               if (frame_start) begin
                  wr_buf_q     <= ~wr_buf_q;
                  disp_valid_q <= 1'b1;
                  idx_q        <= 10'd0;
                  tcnt_q       <= '0;
                  prev_valid_q <= 1'b0;
                  state_q      <= ST_ARMED;
                  armed_q      <= 1'b1;
                  triggered_q  <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_ARMED;
               armed_q     <= 1'b1;
               triggered_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_wr_en)
         mem_q[w_wr_addr] <= sample;
      rd_data_q <= mem_q[{~wr_buf_q, pixel_x}];
   end

   logic [9:0] w_trace_row;
   logic [9:0] w_level_row;
   logic       w_in_view;
   logic       w_on_trace;
   logic       w_on_level;
   logic       w_on_grid;

   always_comb begin
      w_trace_row = T_BASE - {2'b00, rd_data_q};
      w_level_row = T_BASE - {2'b00, trig_level};
      w_in_view   = act1_q && (y1_q < V_LIM);
      w_on_trace  = w_in_view && disp_valid_q && (x1_q < H_LIM) && (y1_q == w_trace_row);
      w_on_level  = w_in_view && (y1_q == w_level_row);
      w_on_grid   = w_in_view && (((x1_q & G_MASK) == 10'd0) || ((y1_q & G_MASK) == 10'd0));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x1_q   <= 10'd0;
         y1_q   <= 10'd0;
         act1_q <= 1'b0;
         r_q    <= 8'h00;
         g_q    <= 8'h00;
         b_q    <= 8'h00;
      end else begin
         x1_q   <= pixel_x;
         y1_q   <= pixel_y;
         act1_q <= pixel_active;
         if (w_on_trace) begin
            r_q <= 8'hFF; g_q <= 8'hFF; b_q <= 8'h00;
         end else if (w_on_level) begin
            r_q <= 8'hFF; g_q <= 8'h00; b_q <= 8'h00;
         end else if (w_on_grid) begin
            r_q <= 8'h40; g_q <= 8'h40; b_q <= 8'h40;
         end else begin
            r_q <= 8'h00; g_q <= 8'h00; b_q <= 8'h00;
         end
      end
   end

   assign colour_R  = r_q;
   assign colour_G  = g_q;
   assign colour_B  = b_q;
   assign armed     = armed_q;
   assign triggered = triggered_q;

endmodule
`default_nettype wire

// File: tb/tb_scope_trace_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scope_trace_renderer
// Self-checking bench for scope_trace_renderer (normal-mode and auto-mode DUTs).
// Revision : 1.0
// ============================================================================
module tb_scope_trace_renderer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_valid = 1'b0;
   logic [7:0] sample = 8'd0;
   logic [7:0] trig_level = 8'd0;
   logic       trig_falling = 1'b0;
   logic       frame_start = 1'b0;
   logic       pixel_active = 1'b0;
   logic [9:0] pixel_x = 10'd0;
   logic [9:0] pixel_y = 10'd0;
   logic [7:0] colour_R, colour_G, colour_B;
   logic       armed, triggered;
   logic [7:0] a_R, a_G, a_B;
   logic       a_armed, a_triggered;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [23:0] exp_q[$];

   always #20 clk = ~clk;

   scope_trace_renderer #(.AUTO_TIMEOUT(0)) dut (
      .clock(clk), .reset(rst), .sample_valid(sample_valid), .sample(sample),
      .trig_level(trig_level), .trig_falling(trig_falling), .frame_start(frame_start),
      .pixel_active(pixel_active), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .colour_R(colour_R), .colour_G(colour_G), .colour_B(colour_B),
      .armed(armed), .triggered(triggered)
   );

   scope_trace_renderer #(.AUTO_TIMEOUT(16)) dut_auto (
      .clock(clk), .reset(rst), .sample_valid(sample_valid), .sample(sample),
      .trig_level(trig_level), .trig_falling(trig_falling), .frame_start(frame_start),
      .pixel_active(pixel_active), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .colour_R(a_R), .colour_G(a_G), .colour_B(a_B),
      .armed(a_armed), .triggered(a_triggered)
   );

   // Independent colour reference: captured ramp starts at 128 and wraps mod 256.
   function automatic logic [23:0] model_colour(input int x, input int y, input bit act,
                                                input bit valid, input int lvl);
      if (!act) return 24'h000000;
      if (valid && x < 640 && y == 367 - ((128 + x) % 256)) return 24'hFFFF00;
      if (y == 367 - lvl) return 24'hFF0000;
      if (x % 64 == 0 || y % 64 == 0) return 24'h404040;
      return 24'h000000;
   endfunction

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); @(negedge clk); rst = 1'b0;
   endtask

   task automatic send_sample(input logic [7:0] s);
      @(negedge clk); sample = s; sample_valid = 1'b1;
      @(negedge clk); sample_valid = 1'b0;
   endtask

   task automatic feed_ramp(input int n);
      for (int v = 0; v < n; v++) send_sample(8'(v));
   endtask

   task automatic pulse_frame();
      @(negedge clk); frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0;
   endtask

   // Drives one pixel and returns on the falling edge where its colour is due.
   task automatic show_pixel(input int x, input int y, input bit act);
      @(negedge clk); pixel_x = 10'(x); pixel_y = 10'(y); pixel_active = act;
      @(negedge clk); pixel_active = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [23:0] got, want;
      do_reset();
      tests_run++;
      if ({armed, triggered} !== 2'b10) begin
         tests_failed++;
         $display("FAIL reset_flags: got armed=%b trig=%b want armed=1 trig=0", armed, triggered);
      end
      tests_run++;
      if ({colour_R, colour_G, colour_B} !== 24'h0) begin
         tests_failed++;
         $display("FAIL reset_colour: got %h want 000000", {colour_R, colour_G, colour_B});
      end
      trig_level = 8'd0;
      exp_q.push_back(24'h000000);
      show_pixel(100, 200, 1'b1);
      got = {colour_R, colour_G, colour_B}; want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL reset_pixel_100_200: got %h want %h", got, want);
      end
   endtask

   task automatic test_ramp_capture();
      int px[5] = '{0, 0, 1, 1, 639};
      int py[5] = '{239, 239, 238, 240, 112};
      logic [23:0] ex[5] = '{24'hFF0000, 24'hFFFF00, 24'hFFFF00, 24'h000000, 24'hFFFF00};
      logic [23:0] got, want;
      do_reset();
      trig_falling = 1'b0; trig_level = 8'd128;
      feed_ramp(128);
      tests_run++;
      if ({armed, triggered} !== 2'b10) begin
         tests_failed++;
         $display("FAIL ramp_pre_trigger: got armed=%b trig=%b want 1/0", armed, triggered);
      end
      send_sample(8'd128);
      tests_run++;
      if ({armed, triggered} !== 2'b01) begin
         tests_failed++;
         $display("FAIL ramp_trigger_128: got armed=%b trig=%b want 0/1", armed, triggered);
      end
      for (int v = 129; v < 768; v++) send_sample(8'(v));
      tests_run++;
      if ({armed, triggered} !== 2'b01) begin
         tests_failed++;
         $display("FAIL ramp_full: got armed=%b trig=%b want 0/1", armed, triggered);
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            pulse_frame();
            tests_run++;
            if ({armed, triggered} !== 2'b10) begin
               tests_failed++;
               $display("FAIL ramp_swap_flags: got armed=%b trig=%b want 1/0", armed, triggered);
            end
         end
         exp_q.push_back(ex[i]);
         show_pixel(px[i], py[i], 1'b1);
         got = {colour_R, colour_G, colour_B}; want = exp_q.pop_front();
         tests_run++;
         if (got !== want) begin
            tests_failed++;
            $display("FAIL ramp_pixel_%0d_%0d: got %h want %h", px[i], py[i], got, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] got, want;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            got = {colour_R, colour_G, colour_B}; want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
               tests_failed++;
               $display("FAIL b2b_x%0d: got %h want %h", i - 2, got, want);
            end
         end
         if (i < 16) begin
            pixel_x = 10'(i); pixel_y = 10'd230; pixel_active = (i != 12);
            exp_q.push_back(model_colour(i, 230, i != 12, 1'b1, 128));
         end else begin
            pixel_active = 1'b0;
         end
      end
   endtask

   task automatic test_level_grid();
      int px[4] = '{64, 64, 65, 64};
      int py[4] = '{267, 100, 101, 267};
      bit pa[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [23:0] ex[4] = '{24'hFF0000, 24'h404040, 24'h000000, 24'h000000};
      logic [23:0] got, want;
      do_reset();
      trig_level = 8'd100;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(ex[i]);
         show_pixel(px[i], py[i], pa[i]);
         got = {colour_R, colour_G, colour_B}; want = exp_q.pop_front();
         tests_run++;
         if (got !== want) begin
            tests_failed++;
            $display("FAIL level_grid_%0d_%0d_act%0d: got %h want %h", px[i], py[i], pa[i], got, want);
         end
      end
   endtask

   task automatic test_falling();
      do_reset();
      trig_falling = 1'b1; trig_level = 8'd150;
      send_sample(8'd200);
      tests_run++;
      if ({armed, triggered} !== 2'b10) begin
         tests_failed++;
         $display("FAIL falling_200_alone: got armed=%b trig=%b want 1/0", armed, triggered);
      end
      send_sample(8'd150);
      tests_run++;
      if ({armed, triggered} !== 2'b01) begin
         tests_failed++;
         $display("FAIL falling_150: got armed=%b trig=%b want 0/1", armed, triggered);
      end
      trig_falling = 1'b0;
   endtask

   task automatic test_auto_timeout();
      do_reset();
      trig_level = 8'd200;
      for (int i = 0; i < 15; i++) send_sample(8'd50);
      tests_run++;
      if ({a_armed, a_triggered} !== 2'b10) begin
         tests_failed++;
         $display("FAIL auto_15: got armed=%b trig=%b want 1/0", a_armed, a_triggered);
      end
      send_sample(8'd50);
      tests_run++;
      if ({a_armed, a_triggered} !== 2'b01) begin
         tests_failed++;
         $display("FAIL auto_16: got armed=%b trig=%b want 0/1", a_armed, a_triggered);
      end
      for (int i = 0; i < 40; i++) send_sample(8'd50);
      tests_run++;
      if ({armed, triggered} !== 2'b10) begin
         tests_failed++;
         $display("FAIL auto_off_stays_armed: got armed=%b trig=%b want 1/0", armed, triggered);
      end
   endtask

   task automatic test_reset_mid_capture();
      logic [23:0] got, want;
      do_reset();
      trig_level = 8'd128;
      feed_ramp(428);
      pulse_frame();
      tests_run++;
      if ({armed, triggered} !== 2'b01) begin
         tests_failed++;
         $display("FAIL capture_ignores_frame: got armed=%b trig=%b want 0/1", armed, triggered);
      end
      do_reset();
      tests_run++;
      if ({armed, triggered} !== 2'b10) begin
         tests_failed++;
         $display("FAIL mid_reset_flags: got armed=%b trig=%b want 1/0", armed, triggered);
      end
      exp_q.push_back(24'h000000);
      show_pixel(1, 238, 1'b1);
      got = {colour_R, colour_G, colour_B}; want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL mid_reset_hidden: got %h want %h", got, want);
      end
      feed_ramp(768);
      pulse_frame();
      exp_q.push_back(24'hFFFF00);
      show_pixel(1, 238, 1'b1);
      got = {colour_R, colour_G, colour_B}; want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL mid_reset_recapture: got %h want %h", got, want);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_capture();
      test_back_to_back();
      test_level_grid();
      test_falling();
      test_auto_timeout();
      test_reset_mid_capture();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
